// File: rtl/dqs_dly_scan.sv
// dqs_dly_scan: sweeps the 5-bit ODELAY tap through the odelay_pipe ld/set
// handshake. At each tap it compares the received DQS level against the
// expected level, finds the first contiguous passing window and programs the
// window centre back into the delay line.
module dqs_dly_scan #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SAMPLES       = 8,
    parameter logic [4:0]  DEFAULT_DELAY = 5'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dly_ready,
    input  logic       sample_in,
    input  logic       expected_in,
    output logic [4:0] dly_data,
    output logic       ld,
    output logic       set,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [4:0] win_first,
    output logic [4:0] win_last
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_SET       = 3'd2;
    localparam logic [2:0] S_SETTLE    = 3'd3;
    localparam logic [2:0] S_SAMPLE    = 3'd4;
    localparam logic [2:0] S_APPLY_LD  = 3'd5;
    localparam logic [2:0] S_APPLY_SET = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLES - 1);

    logic [2:0] state_q, state_d;
    logic [4:0] cur_q, cur_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fail_q, fail_d;
    logic       in_win_q, in_win_d;
    logic       found_q, found_d;
    logic [4:0] first_q, first_d;
    logic [4:0] last_q, last_d;
    logic [4:0] dly_q, dly_d;

    logic       mis;
    logic       tap_pass;
    logic [5:0] centre_sum;

    assign mis = sample_in ^ expected_in;

    // Next-state and datapath updates; dly_d is loaded on entry to each
    // ld-issuing state so the tap is already stable during the ld cycle.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        fail_d     = fail_q;
        in_win_d   = in_win_q;
        found_d    = found_q;
        first_d    = first_q;
        last_d     = last_q;
        dly_d      = dly_q;
        tap_pass   = 1'b0;
        centre_sum = '0;
        case (state_q)
            S_IDLE: begin
                if (start && dly_ready) begin
                    state_d  = S_LOAD;
                    cur_d    = '0;
                    found_d  = 1'b0;
                    first_d  = '0;
                    last_d   = '0;
                    in_win_d = 1'b0;
                    dly_d    = '0;
                end
            end
            S_LOAD: begin
                state_d = S_SET;
            end
            S_SET: begin
                state_d = S_SETTLE;
                cnt_d   = '0;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                    fail_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    // Last compare folds in combinationally: no extra cycle.
                    tap_pass = !(fail_q || mis);
                    if (tap_pass) begin
                        if (!in_win_q) begin
                            first_d  = cur_q;
                            in_win_d = 1'b1;
                            found_d  = 1'b1;
                        end
                        last_d = cur_q;
                    end
                    if ((!tap_pass && in_win_q) || (cur_q == 5'd31)) begin
                        state_d    = S_APPLY_LD;
                        // Uses the _d values so a pass on this final tap counts.
                        centre_sum = {1'b0, first_d} + {1'b0, last_d};
                        dly_d      = found_d ? centre_sum[5:1] : DEFAULT_DELAY;
                    end else begin
                        state_d = S_LOAD;
                        cur_d   = cur_q + 5'd1;
                        dly_d   = cur_q + 5'd1;
                    end
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                    fail_d = fail_q || mis;
                end
            end
            S_APPLY_LD: begin
                state_d = S_APPLY_SET;
            end
            S_APPLY_SET: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            cnt_q    <= '0;
            fail_q   <= 1'b0;
            in_win_q <= 1'b0;
            found_q  <= 1'b0;
            first_q  <= '0;
            last_q   <= '0;
            dly_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            fail_q   <= fail_d;
            in_win_q <= in_win_d;
            found_q  <= found_d;
            first_q  <= first_d;
            last_q   <= last_d;
            dly_q    <= dly_d;
        end
    end

    assign dly_data  = dly_q;
    assign ld        = (state_q == S_LOAD) || (state_q == S_APPLY_LD);
    assign set       = (state_q == S_SET)  || (state_q == S_APPLY_SET);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign found     = found_q;
    assign win_first = first_q;
    assign win_last  = last_q;

endmodule

// File: tb/tb_dqs_dly_scan.sv
// Bench for dqs_dly_scan: per-tap pass/fail pattern model with cycle-offset
// expectations, plus literal checks of the directed scenarios.
module tb_dqs_dly_scan;

    localparam int S   = 4;
    localparam int N   = 8;
    localparam int P   = 2 + S + N;
    localparam int DEF = 7;

    logic       clk = 1'b0;
    logic       rst, start, dly_ready, sample_in, expected_in;
    logic [4:0] dly_data, win_first, win_last;
    logic       ld, set, busy, done, found;

    always #5 clk = ~clk;

    dqs_dly_scan #(
        .SETTLE_CYCLES(S),
        .SAMPLES(N),
        .DEFAULT_DELAY(5'(DEF))
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dly_ready(dly_ready),
        .sample_in(sample_in), .expected_in(expected_in),
        .dly_data(dly_data), .ld(ld), .set(set), .busy(busy), .done(done),
        .found(found), .win_first(win_first), .win_last(win_last)
    );

    int checks = 0;
    int errors = 0;

    logic [4:0] e_dly, e_first, e_last;
    logic       e_ld, e_set, e_busy, e_done, e_found;
    bit         chk_en = 0;

    // fsamp[k] < 0: tap k passes; otherwise the SAMPLE index that mismatches.
    int fsamp[32];
    int m_K, m_first, m_last, m_app;
    bit m_found;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ld", ld, e_ld);
            chk("set", set, e_set);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("dly_data", dly_data, e_dly);
            if (!e_busy) begin
                chk("found", found, e_found);
                chk("win_first", win_first, e_first);
                chk("win_last", win_last, e_last);
            end
        end
    end

    function automatic void model();
        bit in_w;
        in_w = 0; m_found = 0; m_first = 0; m_last = 0; m_K = 32;
        for (int k = 0; k < 32; k++) begin
            if (fsamp[k] < 0) begin
                if (!in_w) begin
                    in_w = 1; m_found = 1; m_first = k;
                end
                m_last = k;
            end else if (in_w) begin
                m_K = k + 1;
                break;
            end
        end
        m_app = m_found ? (m_first + m_last) / 2 : DEF;
    endfunction

    task automatic set_window(input int a, input int b);
        for (int k = 0; k < 32; k++)
            fsamp[k] = (k >= a && k <= b) ? -1 : int'($urandom_range(0, N - 1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit st, input bit rdy);
        for (int i = 0; i < n; i++) begin
            start = st; dly_ready = rdy;
            expected_in = 1'($urandom); sample_in = 1'($urandom);
            e_ld = 0; e_set = 0; e_done = 0; e_busy = 0;
            tick();
        end
        start = 0; dly_ready = 1;
    endtask

    task automatic run_scan(input int busy_start_at, input int rst_at, output int done_off);
        int base;
        model();
        base = 1 + m_K * P;
        done_off = -1;
        start = 1; dly_ready = 1;
        tick();
        start = 0;
        for (int o = 1; o <= base + 2; o++) begin
            bit mm;
            int k, ph;
            mm = 1'($urandom);
            e_ld = 0; e_set = 0; e_done = 0; e_busy = 1;
            if (o < base) begin
                k = (o - 1) / P;
                ph = (o - 1) % P;
                e_ld = (ph == 0);
                e_set = (ph == 1);
                e_dly = 5'(k);
                if (ph >= 2 + S) mm = (fsamp[k] == ph - 2 - S);
            end else if (o == base) begin
                e_ld = 1; e_dly = 5'(m_app);
            end else if (o == base + 1) begin
                e_set = 1;
            end else begin
                e_done = 1; e_busy = 0;
                e_found = m_found; e_first = 5'(m_first); e_last = 5'(m_last);
            end
            expected_in = 1'($urandom);
            sample_in = expected_in ^ mm;
            start = (o == busy_start_at);
            rst = (o == rst_at);
            @(negedge clk);
            if (done) done_off = o;
            tick();
            if (o == rst_at) begin
                rst = 0; start = 0;
                e_ld = 0; e_set = 0; e_done = 0; e_busy = 0;
                e_dly = 0; e_found = 0; e_first = 0; e_last = 0;
                return;
            end
        end
        start = 0;
        e_ld = 0; e_set = 0; e_done = 0; e_busy = 0;
    endtask

    initial begin
        int d, a, b;
        rst = 1; start = 0; dly_ready = 1; sample_in = 0; expected_in = 0;
        e_ld = 0; e_set = 0; e_done = 0; e_busy = 0;
        e_dly = 0; e_found = 0; e_first = 0; e_last = 0;
        tick();
        chk_en = 1;
        tick(); tick();
        rst = 0;
        chk("rst_dly", dly_data, 0);
        chk("rst_busy", busy, 0);
        idle(3, 0, 1);

        // 1: all taps pass
        set_window(0, 31);
        run_scan(-1, -1, d);
        chk("s1_latency", d, 451);
        chk("s1_found", found, 1);
        chk("s1_first", win_first, 0);
        chk("s1_last", win_last, 31);
        chk("s1_dly", dly_data, 15);
        idle(3, 0, 1);

        // 2: window 10..20
        set_window(10, 20);
        run_scan(-1, -1, d);
        chk("s2_latency", d, 311);
        chk("s2_first", win_first, 10);
        chk("s2_last", win_last, 20);
        chk("s2_dly", dly_data, 15);
        idle(3, 0, 1);

        // 3: nothing passes
        set_window(40, 40);
        run_scan(-1, -1, d);
        chk("s3_latency", d, 451);
        chk("s3_found", found, 0);
        chk("s3_dly", dly_data, 7);
        idle(3, 0, 1);

        // 4: window 5..25 broken at tap 12
        set_window(5, 25);
        fsamp[12] = 3;
        run_scan(-1, -1, d);
        chk("s4_latency", d, 185);
        chk("s4_first", win_first, 5);
        chk("s4_last", win_last, 11);
        chk("s4_dly", dly_data, 8);

        // 5: start ignored without dly_ready, and while busy
        idle(4, 1, 0);
        idle(3, 0, 1);
        chk("s5_busy", busy, 0);
        set_window(0, 31);
        run_scan(50, -1, d);
        chk("s5_latency", d, 451);
        chk("s5_dly", dly_data, 15);
        idle(3, 0, 1);

        // 6: reset during SAMPLE of tap 6, then a fresh scan from tap 0
        set_window(0, 31);
        run_scan(-1, 1 + 6 * P + 2 + S + 2, d);
        idle(5, 0, 1);
        chk("s6_dly", dly_data, 0);
        chk("s6_found", found, 0);
        run_scan(-1, -1, d);
        chk("s6_latency", d, 451);
        idle(3, 0, 1);

        // Randomised windows, with optional break inside the window
        for (int it = 0; it < 6; it++) begin
            a = int'($urandom_range(0, 31));
            b = int'($urandom_range(a, 31));
            if ($urandom % 4 == 0) begin
                a = 40; b = 40;
            end
            set_window(a, b);
            if (($urandom % 2 == 1) && (b > a) && (b < 32))
                fsamp[$urandom_range(a + 1, b)] = int'($urandom_range(0, N - 1));
            run_scan(-1, -1, d);
            model();
            chk("rnd_latency", d, 1 + m_K * P + 2);
            idle(int'($urandom_range(1, 4)), 0, 1);
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
